div_seq16: RTL and testbench
============================

# div_seq16

Sequential unsigned 16-bit restoring-division controller and shift-register datapath. Sits directly upstream of the 16-bit registered subtractor stage: drives its operand and enable inputs once per quotient bit, consumes its difference and completion flag, and accumulates the quotient and remainder. It produces one quotient/remainder pair per `start`/`done` transaction.

## Interface
- `WIDTH`, 16, operand width; must equal the subtractor width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `dividend` in WIDTH: captured on accepted `start`.
- `divisor` in WIDTH: captured on accepted `start`.
- `sub_a` out WIDTH: subtractor minuend (`Number`).
- `sub_b` out WIDTH: subtractor subtrahend (`Number2`).
- `sub_en` out 1: subtractor `Enable`.
- `sub_result` in WIDTH: subtractor difference (`Sub_Output`).
- `sub_flag` in 1: subtractor completion (`FLAG`).
- `quotient` out WIDTH: result, held until the next result.
- `remainder` out WIDTH: result, held until the next result.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle result strobe.
- `div_zero` out 1: divide-by-zero indicator, valid with `done`.

## Operation
- Internal state: `q_reg` (WIDTH), `d_reg` (WIDTH), `rem` (WIDTH), `rem_sh` (WIDTH+1), `ge` (1), `cnt` (4 bits).
- FSM states: IDLE, SUB, WAIT, DONE.
- IDLE, `start`=1:
  - `q_reg`←dividend, `d_reg`←divisor, `rem`←0, `cnt`←0.
  - Go to SUB.
- SUB:
  - Form `rem_sh` = {rem, q_reg[MSB]}.
  - `sub_a`=rem_sh[WIDTH-1:0], `sub_b`=d_reg, `sub_en`=1.
  - Register `ge` = (rem_sh ≥ {0,d_reg}), a 17-bit compare done internally. The subtractor has no borrow output.
  - `q_reg`←q_reg<<1. Go to WAIT.
- WAIT:
  - `sub_en`=0.
  - Stay in WAIT while `sub_flag`=0. This stall tolerates extra subtractor latency.
  - When `sub_flag`=1:
    - If `ge`: `rem`←sub_result and `q_reg[0]`←1. The low 16 bits are exact because the difference is less than the divisor.
    - Else: `rem`←rem_sh[WIDTH-1:0] and `q_reg[0]`←0.
    - `cnt`←cnt+1.
    - Go to DONE if `cnt`=15, else to SUB.
- DONE:
  - `done`=1, `quotient`←q_reg, `remainder`←rem.
  - Next state IDLE unconditionally.
- `start` outside IDLE: ignored, no queuing.
- `sub_a`/`sub_b` hold their last value when `sub_en`=0.
- `dividend`/`divisor` may change freely once the request is accepted.

## Timing
- Reset values:
  - State IDLE.
  - `quotient`, `remainder`, `sub_a`, `sub_b`: 0.
  - `sub_en`, `busy`, `done`, `div_zero`: 0.
- Reset is synchronous, so it takes effect on the next `clk` edge with `rst`=0.
- Reset mid-operation: abort, return to IDLE, clear all outputs. No `done` is produced.
- Nominal latency, with the subtractor answering in 1 cycle:
  - 2 cycles per bit, 32 cycles in SUB/WAIT.
  - `done` is high in the cycle after the 32nd post-accept edge, i.e. 33 cycles after the accepting edge.
- `busy` rises the cycle after acceptance and falls with `done`.
- A new `start` is accepted in the cycle immediately after DONE at the earliest.
- `sub_en` is a one-cycle pulse per bit, 16 pulses per division.

## Configuration
- Macro: `DIV_ZERO_DETECT_EN`.
- Defined:
  - On accepted `start` with `divisor`=0, the FSM goes IDLE→DONE directly. `done` is high in the following cycle.
  - Results: `quotient`=all ones, `remainder`=dividend, `div_zero`=1.
  - No `sub_en` pulses are issued.
- Undefined:
  - `div_zero` is tied 0.
  - A zero divisor runs the full 32-cycle sequence and naturally yields `quotient`=all ones, `remainder`=dividend.

## Structure
- Package `div_pkg`:
  - State enum `div_state_t` (IDLE, SUB, WAIT, DONE).
  - Localparams `DIV_WIDTH`=16 and `DIV_BITS`=16.
- One sub-module, `div_shift_reg`:
  - Holds `q_reg`/`rem`/`rem_sh` and performs the shift, compare and restore.
  - Controlled by load/shift/commit strobes from the FSM.
- The subtractor is not instantiated here; the parent wires it beside this block.

## Test plan
- 100/7 → after 33 cycles: `quotient`=14, `remainder`=2, exactly 16 `sub_en` pulses, `done` one cycle.
- 0xFFFF/0x8001 → `quotient`=1, `remainder`=0x7FFE (exercises the 17-bit compare); 0xFFFF/0xFFFF → 1, 0.
- Subtractor model with `sub_flag` delayed 3 cycles, 0x1234/0x0010 → `quotient`=0x0123, `remainder`=4, latency 80 cycles.
- `start` re-asserted mid-division with 5/1 → ignored; first result 100/7 unchanged; next `start` after `done` gives 5, 0.
- `rst`=0 for one edge at cycle 10 → `busy`=0, all outputs 0, no `done`; a subsequent 9/3 → 3, 0.
- Divisor 0, dividend 0x00AB:
  - With `DIV_ZERO_DETECT_EN`: `done` 1 cycle after accept, 0xFFFF/0x00AB, `div_zero`=1.
  - Without it: 33 cycles, same values, `div_zero`=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// The quotient bit count always equals the operand width.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_BITS  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_shift_reg.sv
// Quotient/remainder shift datapath: load on start, shift + 17-bit compare per bit, restore on commit.
// Registered state only; subtractor operands are muxed live during the shift cycle and held otherwise.
module div_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             commit,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] sub_result,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] sh_lo;
  logic [WIDTH-1:0] b_hold;
  logic [WIDTH:0]   rem_sh;
  logic             ge;

  assign rem_sh = {rem, q_reg[WIDTH-1]};

  // The shifted remainder can reach 2^WIDTH, so the compare needs the extra bit
  // that the subtractor itself does not report.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg  <= '0;
      d_reg  <= '0;
      rem    <= '0;
      sh_lo  <= '0;
      b_hold <= '0;
      ge     <= 1'b0;
    end else if (load) begin
      q_reg <= dividend;
      d_reg <= divisor;
      rem   <= '0;
    end else if (shift) begin
      sh_lo  <= rem_sh[WIDTH-1:0];
      b_hold <= d_reg;
      ge     <= (rem_sh >= {1'b0, d_reg});
      q_reg  <= q_reg << 1;
    end else if (commit) begin
      rem   <= rem_next;
      q_reg <= q_next;
    end
  end

  always_comb begin
    q_next   = {q_reg[WIDTH-1:1], ge};
    rem_next = ge ? sub_result : sh_lo;
    sub_a    = shift ? rem_sh[WIDTH-1:0] : sh_lo;
    sub_b    = shift ? d_reg : b_hold;
  end

endmodule

// File: rtl/div_seq16.sv
// Sequential unsigned restoring divider driving an external registered subtractor; 2 cycles/bit nominal, done 33 cycles after accept.
// Stalls in WAIT until sub_flag; start is ignored while busy. Optional DIV_ZERO_DETECT_EN short-circuits a zero divisor.
module div_seq16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_en,
  input  logic [WIDTH-1:0] sub_result,
  input  logic             sub_flag,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [3:0] LAST_BIT = 4'(DIV_BITS - 1);

  div_state_t       state, state_nxt;
  logic [3:0]       cnt;
  logic             load, shift, commit, last;
  logic [WIDTH-1:0] q_next, rem_next;

`ifdef DIV_ZERO_DETECT_EN
  logic zero_go;
  logic dz_q;
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign last = (cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    commit    = 1'b0;
    sub_en    = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
`ifdef DIV_ZERO_DETECT_EN
    zero_go   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SUB;
`ifdef DIV_ZERO_DETECT_EN
          if (divisor == '0) begin
            zero_go   = 1'b1;
            state_nxt = DONE;
          end
`endif
        end
      end
      SUB: begin
        shift     = 1'b1;
        sub_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (sub_flag) begin
          commit    = 1'b1;
          state_nxt = last ? DONE : SUB;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are captured on the edge into DONE so they are valid alongside done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= '0;
      else if (commit)
        cnt <= cnt + 4'd1;
      if (commit && last) begin
        quotient  <= q_next;
        remainder <= rem_next;
      end
`ifdef DIV_ZERO_DETECT_EN
      dz_q <= zero_go;
      if (zero_go) begin
        quotient  <= '1;
        remainder <= dividend;
      end
`endif
    end
  end

  div_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift      (shift),
    .commit     (commit),
    .dividend   (dividend),
    .divisor    (divisor),
    .sub_result (sub_result),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .q_next     (q_next),
    .rem_next   (rem_next)
  );

endmodule

// File: tb/tb_div_seq16.sv
// Bench for div_seq16 with a behavioural registered-subtractor model of configurable latency.
module tb_div_seq16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] dividend, divisor, sub_a, sub_b, sub_result, quotient, remainder;
  logic        sub_en, sub_flag, busy, done, div_zero;

  int vecs = 0;
  int errs = 0;
  int lat  = 1;
  int pend = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  always #5 clk = ~clk;

  div_seq16 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .sub_a(sub_a), .sub_b(sub_b), .sub_en(sub_en), .sub_result(sub_result),
    .sub_flag(sub_flag), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  // Subtractor model: difference registered on enable, flag after lat cycles.
  always @(posedge clk) begin
    if (sub_en) begin
      sub_result <= sub_a - sub_b;
      pend       <= lat;
    end else if (pend > 0) begin
      pend <= pend - 1;
    end
  end
  assign sub_flag = (pend == 1);

  logic [15:0] res_q, res_r, aft_q, aft_r;
  logic        res_dz, res_seen, res_busy, aft_done, aft_busy;
  int          res_edges, res_pulses;

  // Drives one request from a negedge in IDLE; returns at the negedge of the cycle after done.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        input int poke_at, input int rst_at, input int max_edges);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    res_edges = 0; res_pulses = 0; res_seen = 1'b0;
    res_q = '0; res_r = '0; res_dz = 1'b0; res_busy = 1'b0;
    while (res_edges < max_edges) begin
      @(negedge clk);
      if (sub_en) res_pulses++;
      if (done) begin
        res_seen = 1'b1; res_q = quotient; res_r = remainder;
        res_dz = div_zero; res_busy = busy;
        break;
      end
      start = (res_edges == poke_at);
      if (start) begin dividend = 16'd5; divisor = 16'd1; end
      rst = (res_edges == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk);
      res_edges++;
    end
    start = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    aft_done = done; aft_busy = busy; aft_q = quotient; aft_r = remainder;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dividend = 16'h1111; divisor = 16'h2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({busy, done, div_zero, sub_en} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags: got %b want 0000", {busy, done, div_zero, sub_en});
    end
    vecs++;
    if ({quotient, remainder} !== 32'h0) begin
      errs++; $display("FAIL reset_results: got %h/%h want 0/0", quotient, remainder);
    end
    vecs++;
    if ({sub_a, sub_b} !== 32'h0) begin
      errs++; $display("FAIL reset_operands: got %h/%h want 0/0", sub_a, sub_b);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    lat = 1;
    do_div(16'd100, 16'd7, -1, -1, 200);
    vecs++;
    if (res_seen !== 1'b1) begin errs++; $display("FAIL basic_done: no done within budget"); end
    vecs++;
    if (res_q !== 16'd14 || res_r !== 16'd2) begin
      errs++; $display("FAIL basic_result: got %0d r %0d want 14 r 2", res_q, res_r);
    end
    vecs++;
    if (res_edges != 32) begin errs++; $display("FAIL basic_latency: got %0d want 32", res_edges); end
    vecs++;
    if (res_pulses != 16) begin errs++; $display("FAIL basic_pulses: got %0d want 16", res_pulses); end
    vecs++;
    if (res_busy !== 1'b1 || aft_busy !== 1'b0 || aft_done !== 1'b0) begin
      errs++; $display("FAIL basic_strobe: busy@done %b busy_after %b done_after %b want 1 0 0",
                       res_busy, aft_busy, aft_done);
    end
    vecs++;
    if (aft_q !== 16'd14 || aft_r !== 16'd2) begin
      errs++; $display("FAIL basic_hold: got %0d r %0d want 14 r 2", aft_q, aft_r);
    end
  endtask

  task automatic test_boundaries();
    lat = 1;
    do_div(16'hFFFF, 16'h8001, -1, -1, 200);
    vecs++;
    if (res_q !== 16'h0001 || res_r !== 16'h7FFE) begin
      errs++; $display("FAIL bound_8001: got %h r %h want 0001 r 7ffe", res_q, res_r);
    end
    do_div(16'hFFFF, 16'hFFFF, -1, -1, 200);
    vecs++;
    if (res_q !== 16'h0001 || res_r !== 16'h0000) begin
      errs++; $display("FAIL bound_ffff: got %h r %h want 0001 r 0000", res_q, res_r);
    end
    do_div(16'h0000, 16'h0005, -1, -1, 200);
    vecs++;
    if (res_q !== 16'h0000 || res_r !== 16'h0000) begin
      errs++; $display("FAIL bound_zero_num: got %h r %h want 0 r 0", res_q, res_r);
    end
  endtask

  task automatic test_slow_sub();
    lat = 4;
    do_div(16'h1234, 16'h0010, -1, -1, 300);
    vecs++;
    if (res_q !== 16'h0123 || res_r !== 16'h0004) begin
      errs++; $display("FAIL slow_result: got %h r %h want 0123 r 0004", res_q, res_r);
    end
    vecs++;
    if (res_edges != 80) begin errs++; $display("FAIL slow_latency: got %0d want 80", res_edges); end
    lat = 1;
  endtask

  task automatic test_start_ignored();
    lat = 1;
    do_div(16'd100, 16'd7, 10, -1, 200);
    vecs++;
    if (res_q !== 16'd14 || res_r !== 16'd2 || res_edges != 32) begin
      errs++; $display("FAIL ignore_first: got %0d r %0d after %0d want 14 r 2 after 32",
                       res_q, res_r, res_edges);
    end
    do_div(16'd5, 16'd1, -1, -1, 200);
    vecs++;
    if (res_q !== 16'd5 || res_r !== 16'd0) begin
      errs++; $display("FAIL ignore_second: got %0d r %0d want 5 r 0", res_q, res_r);
    end
  endtask

  task automatic test_midop_reset();
    lat = 1;
    do_div(16'd100, 16'd7, -1, 10, 60);
    vecs++;
    if (res_seen !== 1'b0) begin errs++; $display("FAIL rst_no_done: got done want none"); end
    vecs++;
    if ({aft_busy, aft_done, div_zero, sub_en} !== 4'b0000 ||
        {aft_q, aft_r, sub_a, sub_b} !== 64'h0) begin
      errs++; $display("FAIL rst_outputs: busy %b q %h r %h a %h b %h want all 0",
                       aft_busy, aft_q, aft_r, sub_a, sub_b);
    end
    do_div(16'd9, 16'd3, -1, -1, 200);
    vecs++;
    if (res_q !== 16'd3 || res_r !== 16'd0) begin
      errs++; $display("FAIL rst_recover: got %0d r %0d want 3 r 0", res_q, res_r);
    end
  endtask

  task automatic test_div_zero();
    lat = 1;
    do_div(16'h00AB, 16'h0000, -1, -1, 200);
    vecs++;
    if (res_q !== 16'hFFFF || res_r !== 16'h00AB) begin
      errs++; $display("FAIL zero_result: got %h r %h want ffff r 00ab", res_q, res_r);
    end
    vecs++;
    if (res_dz !== ZD) begin errs++; $display("FAIL zero_flag: got %b want %b", res_dz, ZD); end
    vecs++;
    if (res_edges != (ZD ? 0 : 32) || res_pulses != (ZD ? 0 : 16)) begin
      errs++; $display("FAIL zero_timing: edges %0d pulses %0d want %0d %0d",
                       res_edges, res_pulses, ZD ? 0 : 32, ZD ? 0 : 16);
    end
  endtask

  // Consecutive random requests: each starts in the first IDLE cycle after the previous done.
  task automatic test_back_to_back();
    logic [15:0] a, b, eq, er;
    int          ee;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(1, 15));
        1:       b = 16'($urandom_range(0, 2));
        2:       b = a >> $urandom_range(0, 8);
        default: b = 16'($urandom);
      endcase
      lat = $urandom_range(1, 4);
      eq  = (b == 16'd0) ? 16'hFFFF : a / b;
      er  = (b == 16'd0) ? a : a % b;
      ee  = (b == 16'd0 && ZD) ? 0 : 16 * (lat + 1);
      do_div(a, b, -1, -1, 300);
      vecs++;
      if (res_q !== eq || res_r !== er || res_edges != ee) begin
        errs++; $display("FAIL rand_%0d: %h/%h lat %0d got %h r %h in %0d want %h r %h in %0d",
                         i, a, b, lat, res_q, res_r, res_edges, eq, er, ee);
      end
    end
    lat = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_slow_sub();
    test_start_ignored();
    test_midop_reset();
    test_div_zero();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
